// File: rtl/z80_mem_bridge_pkg.sv
// Shared definitions for the Z80 memory bridge: state encoding, default widths
// and the value the CPU sees when nothing drives the data bus.
package z80_mem_bridge_pkg;

    localparam int DATA_W     = 8;
    localparam int RAM_ADDR_W = 10;
    localparam int WAIT_W     = 3;   // holds RD_EXTRA - 1 for RD_EXTRA up to 7

    localparam logic [DATA_W-1:0] IDLE_BUS = 8'hFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_WAIT = 3'd2,
        RD_CAP  = 3'd3,
        HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/z80_win_decode.sv
// Combinational address-window compare: sel is high when addr falls inside the
// 2**ADDR_W byte window starting at BASE_ADDR (low ADDR_W bits of the base are
// ignored). Kept separate so the I/O decode can reuse it.
module z80_win_decode #(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic [15:0] addr,
    output logic        sel
);

    // Upper bits equal means every differing bit lies below the window size.
    assign sel = ((addr ^ BASE_ADDR) >> ADDR_W) == 16'h0000;

endmodule

// File: rtl/z80_mem_bridge.sv
// Z80 memory-cycle to synchronous block-RAM bridge. Writes become a single
// mem_we pulse; reads stall the CPU with wait_n until the registered RAM data
// has been captured into cpu_din. HOLD keeps it to one RAM access per CPU cycle.
module z80_mem_bridge
    import z80_mem_bridge_pkg::*;
#(
    parameter int          ADDR_W    = RAM_ADDR_W,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          RD_EXTRA  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    output logic [DATA_W-1:0] cpu_din,
    input  logic              mreq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    output logic              wait_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        WAIT_W'((RD_EXTRA > 0) ? RD_EXTRA - 1 : 0);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   din_d;
    logic                wait_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                we_d;
    logic                sel;

    z80_win_decode #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_win_decode (
        .addr (cpu_addr),
        .sel  (sel)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = cpu_din;
        wait_d  = wait_n;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 1'b0;     // write-enable is only ever a one-cycle pulse

        case (state_q)
            IDLE: begin
                if (!mreq_n && !rd_n) begin
                    // Read wins when both strobes are low.
                    if (sel) begin
                        addr_d  = cpu_addr[ADDR_W-1:0];
                        wait_d  = 1'b0;
                        state_d = RD_ADDR;
                    end else begin
                        din_d   = IDLE_BUS;
                        state_d = HOLD;
                    end
                end else if (!mreq_n && !wr_n) begin
                    if (sel) begin
                        addr_d  = cpu_addr[ADDR_W-1:0];
                        wdata_d = cpu_dout;
                        we_d    = 1'b1;
                    end
                    state_d = HOLD;
                end
            end
            RD_ADDR: begin
                // RAM samples mem_addr on this edge; data is ready one clock later.
                if (RD_EXTRA == 0) begin
                    state_d = RD_CAP;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RD_CAP;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            RD_CAP: begin
                din_d   = mem_rdata;
                wait_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // Stay until the CPU ends its cycle so long strobes cause one access.
                if (mreq_n || (rd_n && wr_n)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset forces the bus-idle values at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cpu_din   <= IDLE_BUS;
            wait_n    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cpu_din   <= din_d;
            wait_n    <= wait_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
        end
    end

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Scoreboard bench for z80_mem_bridge. Two bridges (RD_EXTRA = 0 and 3) share
// one CPU bus, each with its own RAM model. Stimulus pushes expected read
// results and RAM writes into queues; a negedge monitor pops and compares.
module tb_z80_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        mreq_n, rd_n, wr_n;

    logic [7:0]  din0, din3, wdata0, wdata3, rdata0, rdata3;
    logic [9:0]  addr0, addr3;
    logic        wait_n0, wait_n3, we0, we3;

    always #5 clk = ~clk;

    z80_mem_bridge #(.ADDR_W(10), .BASE_ADDR(16'h0000), .RD_EXTRA(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(din0), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .wait_n(wait_n0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_we(we0),
        .mem_rdata(rdata0)
    );

    z80_mem_bridge #(.ADDR_W(10), .BASE_ADDR(16'h0000), .RD_EXTRA(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(din3), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .wait_n(wait_n3), .mem_addr(addr3), .mem_wdata(wdata3), .mem_we(we3),
        .mem_rdata(rdata3)
    );

    // Synchronous 1K x 8 RAM models with registered read.
    // NOTE: RAM contents are not reset, like the real block RAM; the bench only
    // reads locations it has written.
    logic [7:0] ram0 [1024];
    logic [7:0] ram3 [1024];
    always @(posedge clk) begin
        if (we0) ram0[addr0] <= wdata0;
        if (we3) ram3[addr3] <= wdata3;
        rdata0 <= ram0[addr0];
        rdata3 <= ram3[addr3];
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] addr;
        int         w0;
        int         w3;
    } rd_exp_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_exp_t;

    rd_exp_t    rd_q[$];
    wr_exp_t    wr_q[$];
    logic [7:0] ref_mem [1024];
    logic [9:0] last_addr;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return a < 16'h0400;
    endfunction

    // One full CPU memory cycle: model the result, drive strobes, wait for the
    // bus to be released by both bridges, end the cycle, leave one idle clock.
    task automatic cpu_cycle(input bit do_rd, input bit do_wr, input logic [15:0] a,
                             input logic [7:0] d, input int hold);
        rd_exp_t e;
        int      n;
        bit      done;
        if (do_rd) begin
            e.data = in_win(a) ? ref_mem[a % 1024] : 8'hFF;
            if (in_win(a)) last_addr = 10'(a % 1024);
            e.addr = last_addr;
            e.w0   = in_win(a) ? 2 : 0;
            e.w3   = in_win(a) ? 5 : 0;
            rd_q.push_back(e);
        end else if (do_wr && in_win(a)) begin
            ref_mem[a % 1024] = d;
            last_addr = 10'(a % 1024);
            wr_q.push_back('{addr: 10'(a % 1024), data: d});
        end
        cpu_addr = a;
        cpu_dout = d;
        mreq_n   = 1'b0;
        rd_n     = !do_rd;
        wr_n     = !do_wr;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            n++;
            if (n >= 1 + hold && wait_n0 && wait_n3) begin
                done = 1'b1;
            end else if (n > 60) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_timeout: wait_n0=%b wait_n3=%b after %0d cycles", wait_n0, wait_n3, n);
                done = 1'b1;
            end
        end
        mreq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_din0"},   32'(din0),    32'hFF);
        check({tag, "_din3"},   32'(din3),    32'hFF);
        check({tag, "_wait0"},  32'(wait_n0), 32'h1);
        check({tag, "_wait3"},  32'(wait_n3), 32'h1);
        check({tag, "_we0"},    32'(we0),     32'h0);
        check({tag, "_we3"},    32'(we3),     32'h0);
        check({tag, "_addr0"},  32'(addr0),   32'h0);
        check({tag, "_addr3"},  32'(addr3),   32'h0);
    endtask

    // Monitor: read results at the end of each read cycle, RAM writes on each
    // sampled mem_we. Wait-state length is counted in low-sampled clocks.
    bit      prev_rd = 1'b0;
    int      low0 = 0, low3 = 0;
    rd_exp_t m_rd;
    wr_exp_t m_wr;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
            low0 = 0;
            low3 = 0;
        end else begin
            if (!wait_n0) low0++;
            if (!wait_n3) low3++;
            if (prev_rd && !(!mreq_n && !rd_n)) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'(rd_q.size()), 32'h1);
                end else begin
                    m_rd = rd_q.pop_front();
                    check("rd_din0",  32'(din0),  32'(m_rd.data));
                    check("rd_din3",  32'(din3),  32'(m_rd.data));
                    check("rd_addr0", 32'(addr0), 32'(m_rd.addr));
                    check("rd_addr3", 32'(addr3), 32'(m_rd.addr));
                    check("rd_wait0", 32'(low0),  32'(m_rd.w0));
                    check("rd_wait3", 32'(low3),  32'(m_rd.w3));
                end
                low0 = 0;
                low3 = 0;
            end
            prev_rd = !mreq_n && !rd_n;
            if (we0 || we3) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", {30'h0, we3, we0}, 32'h0);
                end else begin
                    m_wr = wr_q.pop_front();
                    check("wr_we0",    32'(we0),    32'h1);
                    check("wr_we3",    32'(we3),    32'h1);
                    check("wr_addr0",  32'(addr0),  32'(m_wr.addr));
                    check("wr_addr3",  32'(addr3),  32'(m_wr.addr));
                    check("wr_data0",  32'(wdata0), 32'(m_wr.data));
                    check("wr_data3",  32'(wdata3), 32'(m_wr.data));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] addr_tab [16] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                   16'h0004, 16'h0005, 16'h0006, 16'h0007,
                                   16'h0010, 16'h0123, 16'h0155, 16'h0200,
                                   16'h02AA, 16'h0300, 16'h03FE, 16'h03FF};
    logic [15:0] ra;
    int          kind;

    initial begin
        rst_n = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        mreq_n = 1'b1;
        rd_n = 1'b1;
        wr_n = 1'b1;
        last_addr = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back.
        cpu_cycle(1'b0, 1'b1, 16'h0123, 8'hA5, 0);
        cpu_cycle(1'b1, 1'b0, 16'h0123, 8'h00, 0);
        // Preload and read with extra wait states on the second bridge.
        cpu_cycle(1'b0, 1'b1, 16'h0005, 8'h77, 0);
        cpu_cycle(1'b0, 1'b1, 16'h0010, 8'h3C, 0);
        cpu_cycle(1'b1, 1'b0, 16'h0010, 8'h00, 0);
        // Outside the window: idle-bus data, no wait, no RAM write.
        cpu_cycle(1'b1, 1'b0, 16'h8000, 8'h00, 0);
        cpu_cycle(1'b0, 1'b1, 16'h8000, 8'h5A, 0);
        // Long write strobe: one pulse only; top address of the window.
        cpu_cycle(1'b0, 1'b1, 16'h03FF, 8'h11, 10);
        cpu_cycle(1'b1, 1'b0, 16'h03FF, 8'h00, 4);
        // Both strobes low: read, no write.
        cpu_cycle(1'b1, 1'b1, 16'h0005, 8'hEE, 0);

        // Reset while a read sits in RD_ADDR.
        cpu_addr = 16'h0123;
        mreq_n = 1'b0;
        rd_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_rd");
        mreq_n = 1'b1;
        rd_n = 1'b1;
        last_addr = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        cpu_cycle(1'b1, 1'b0, 16'h0123, 8'h00, 0);

        // Reset while the write pulse is high: it must drop immediately.
        cpu_addr = 16'h0200;
        cpu_dout = 8'h99;
        mreq_n = 1'b0;
        wr_n = 1'b0;
        @(posedge clk); #1;
        check("we0_before_rst", 32'(we0), 32'h1);
        check("we3_before_rst", 32'(we3), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_wr");
        mreq_n = 1'b1;
        wr_n = 1'b1;
        last_addr = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every table address a known value, then random traffic.
        for (int i = 0; i < 16; i++) begin
            cpu_cycle(1'b0, 1'b1, addr_tab[i], 8'($urandom), 0);
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(16'h0400, 16'hFFFF));
            else                           ra = addr_tab[$urandom_range(0, 15)];
            kind = int'($urandom_range(0, 9));
            cpu_cycle(kind < 5 || kind == 9, kind >= 5, ra, 8'($urandom),
                      int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        repeat (5) @(posedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);
        check("wr_q_drained", 32'(wr_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
